// File: rtl/pwm_timer_mc.sv
// pwm_timer_mc: NCH-channel PWM timer on a simple register bus.
// One shadowed prescaler feeds all channels; each channel counts up or
// up-down, optionally stops after one period, and raises overflow/compare
// events into write-1-to-clear flags gated by an interrupt mask.
module pwm_timer_mc #(
    parameter int DW  = 16,
    parameter int AW  = 12,
    parameter int NCH = 4,
    parameter int CW  = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [DW-1:0]  din,
    input  logic [AW-1:0]  addr,
    input  logic           we,
    output logic [DW-1:0]  dout,
    output logic [NCH-1:0] pwm_p,
    output logic [NCH-1:0] pwm_n,
    output logic           intp
);
    localparam logic [AW-1:0] ADDR_TDIV = AW'(0);
    localparam logic [AW-1:0] ADDR_IFLG = AW'(1);
    localparam logic [AW-1:0] ADDR_IEN  = AW'(2);
    localparam logic [AW-1:0] ADDR_CH0  = AW'(16);
    localparam logic [AW-1:0] CH_SPAN   = AW'(4 * NCH);

    // Programmed values (*_r) and the copies the counters actually use (*_sh_r)
    logic [DW-1:0]  tdiv_r, tdiv_sh_r, div_cnt_r;
    logic [NCH-1:0] en_r, pol_r, mode_r, oneshot_r, dir_r;
    logic [CW-1:0]  top_r [NCH];
    logic [CW-1:0]  cmp_r [NCH];
    logic [CW-1:0]  top_sh_r [NCH];
    logic [CW-1:0]  cmp_sh_r [NCH];
    logic [CW-1:0]  cnt_r [NCH];
    logic [NCH-1:0] ovf_flg_r, cmp_flg_r, ovf_ien_r, cmp_ien_r;

    logic           tick_s, ch_valid_s, wr_tdiv_s, wr_iflg_s, wr_ien_s;
    logic [AW-1:0]  ch_off_s;
    logic [AW-3:0]  ch_idx_s;
    logic [CW-1:0]  cnt_nxt_s [NCH];
    logic [NCH-1:0] dir_nxt_s, ovf_ev_s, cmp_ev_s, pwm_nxt_s;
    logic [NCH-1:0] ovf_clr_s, cmp_clr_s;
    logic [DW-1:0]  rdata_s;

    assign tick_s = (div_cnt_r == tdiv_sh_r);

    // Address decode: global registers and the channel window
    always_comb begin
        ch_off_s   = addr - ADDR_CH0;
        ch_valid_s = (addr >= ADDR_CH0) && (ch_off_s < CH_SPAN);
        ch_idx_s   = ch_off_s[AW-1:2];
        wr_tdiv_s  = we && (addr == ADDR_TDIV);
        wr_iflg_s  = we && (addr == ADDR_IFLG);
        wr_ien_s   = we && (addr == ADDR_IEN);
        if (wr_iflg_s) begin
            ovf_clr_s = din[NCH-1:0];
            cmp_clr_s = din[8+NCH-1:8];
        end else begin
            ovf_clr_s = '0;
            cmp_clr_s = '0;
        end
    end

    // Prescaler: divisor shadow reloads only on the tick cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdiv_r    <= '0;
            tdiv_sh_r <= '0;
            div_cnt_r <= '0;
        end else begin
            if (wr_tdiv_s) tdiv_r <= din;
            if (tick_s) begin
                div_cnt_r <= '0;
                tdiv_sh_r <= tdiv_r;
            end else begin
                div_cnt_r <= div_cnt_r + DW'(1);
            end
        end
    end

    // Per-channel next count, direction, events and PWM level
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            dir_nxt_s[i] = dir_r[i];
            ovf_ev_s[i]  = 1'b0;
            cmp_ev_s[i]  = 1'b0;
            pwm_nxt_s[i] = (en_r[i] && (cnt_r[i] < cmp_sh_r[i])) ? pol_r[i] : ~pol_r[i];
            if (en_r[i] && tick_s) begin
                cmp_ev_s[i] = (cnt_r[i] == cmp_sh_r[i]);
                if (top_sh_r[i] == '0) begin
                    cnt_nxt_s[i] = '0;
                    dir_nxt_s[i] = 1'b0;
                    ovf_ev_s[i]  = 1'b1;
                end else if (!mode_r[i]) begin
                    if (cnt_r[i] >= top_sh_r[i]) begin
                        cnt_nxt_s[i] = '0;
                        dir_nxt_s[i] = 1'b0;
                        ovf_ev_s[i]  = 1'b1;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] + CW'(1);
                        dir_nxt_s[i] = 1'b0;
                    end
                end else if (!dir_r[i]) begin
                    if (cnt_r[i] >= top_sh_r[i]) begin
                        cnt_nxt_s[i] = top_sh_r[i] - CW'(1);
                        dir_nxt_s[i] = 1'b1;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] + CW'(1);
                    end
                end else begin
                    if (cnt_r[i] == '0) begin
                        cnt_nxt_s[i] = CW'(1);
                        dir_nxt_s[i] = 1'b0;
                        ovf_ev_s[i]  = 1'b1;
                    end else begin
                        cnt_nxt_s[i] = cnt_r[i] - CW'(1);
                    end
                end
            end else begin
                cnt_nxt_s[i] = cnt_r[i];
            end
        end
    end

    // Channel state: counting, shadow loads, one-shot stop, bus writes (bus wins)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_r      <= '0;
            pol_r     <= '0;
            mode_r    <= '0;
            oneshot_r <= '0;
            dir_r     <= '0;
            for (int i = 0; i < NCH; i++) begin
                top_r[i]    <= '0;
                cmp_r[i]    <= '0;
                top_sh_r[i] <= '0;
                cmp_sh_r[i] <= '0;
                cnt_r[i]    <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (en_r[i]) begin
                    cnt_r[i] <= cnt_nxt_s[i];
                    dir_r[i] <= dir_nxt_s[i];
                    if (ovf_ev_s[i]) begin
                        top_sh_r[i] <= top_r[i];
                        cmp_sh_r[i] <= cmp_r[i];
                    end
                    if (ovf_ev_s[i] && oneshot_r[i]) en_r[i] <= 1'b0;
                end else begin
                    cnt_r[i]    <= '0;
                    dir_r[i]    <= 1'b0;
                    top_sh_r[i] <= top_r[i];
                    cmp_sh_r[i] <= cmp_r[i];
                end
                if (we && ch_valid_s && (ch_idx_s == (AW-2)'(i))) begin
                    case (ch_off_s[1:0])
                        2'd0: begin
                            en_r[i]      <= din[0];
                            pol_r[i]     <= din[1];
                            mode_r[i]    <= din[2];
                            oneshot_r[i] <= din[3];
                            // Disabling stops the count right at this edge
                            if (!din[0]) begin
                                cnt_r[i] <= '0;
                                dir_r[i] <= 1'b0;
                            end
                        end
                        2'd1:    top_r[i] <= din[CW-1:0];
                        2'd2:    cmp_r[i] <= din[CW-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // Flags (set beats clear), interrupt mask and registered interrupt
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_flg_r <= '0;
            cmp_flg_r <= '0;
            ovf_ien_r <= '0;
            cmp_ien_r <= '0;
            intp      <= 1'b0;
        end else begin
            if (wr_ien_s) begin
                ovf_ien_r <= din[NCH-1:0];
                cmp_ien_r <= din[8+NCH-1:8];
            end
            ovf_flg_r <= (ovf_flg_r & ~ovf_clr_s) | ovf_ev_s;
            cmp_flg_r <= (cmp_flg_r & ~cmp_clr_s) | cmp_ev_s;
            intp      <= |((ovf_flg_r & ovf_ien_r) | (cmp_flg_r & cmp_ien_r));
        end
    end

    // Read mux; unmapped addresses and unused bits return zero
    always_comb begin
        rdata_s = '0;
        if (addr == ADDR_TDIV) begin
            rdata_s = tdiv_r;
        end else if (addr == ADDR_IFLG) begin
            rdata_s[NCH-1:0]   = ovf_flg_r;
            rdata_s[8+NCH-1:8] = cmp_flg_r;
        end else if (addr == ADDR_IEN) begin
            rdata_s[NCH-1:0]   = ovf_ien_r;
            rdata_s[8+NCH-1:8] = cmp_ien_r;
        end else if (ch_valid_s) begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_idx_s == (AW-2)'(i)) begin
                    case (ch_off_s[1:0])
                        2'd0:    rdata_s[3:0]    = {oneshot_r[i], mode_r[i], pol_r[i], en_r[i]};
                        2'd1:    rdata_s[CW-1:0] = top_r[i];
                        2'd2:    rdata_s[CW-1:0] = cmp_r[i];
                        2'd3:    rdata_s[CW-1:0] = cnt_r[i];
                        default: rdata_s = '0;
                    endcase
                end else begin
                    rdata_s = rdata_s;
                end
            end
        end else begin
            rdata_s = '0;
        end
    end

    // Registered read data and differential PWM outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout  <= '0;
            pwm_p <= '1;
            pwm_n <= '0;
        end else begin
            if (!we) dout <= rdata_s;
            pwm_p <= pwm_nxt_s;
            pwm_n <= ~pwm_nxt_s;
        end
    end
endmodule

// File: tb/tb_pwm_timer_mc.sv
// Self-checking bench for pwm_timer_mc: a register-map vector table plus
// hand-timed sequences for counting, flags, shadowing, one-shot and reset.
module tb_pwm_timer_mc;
    localparam int DW = 16, AW = 12, NCH = 4, CW = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [DW-1:0]  din;
    logic [AW-1:0]  addr;
    logic           we;
    logic [DW-1:0]  dout;
    logic [NCH-1:0] pwm_p, pwm_n;
    logic           intp;

    int n_vec = 0;
    int n_err = 0;
    int tri_seq [6] = '{0, 1, 2, 3, 2, 1};

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          chk;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl [19];

    always #5 clk = ~clk;

    pwm_timer_mc #(.DW(DW), .AW(AW), .NCH(NCH), .CW(CW)) dut (
        .clk(clk), .rst(rst), .din(din), .addr(addr), .we(we),
        .dout(dout), .pwm_p(pwm_p), .pwm_n(pwm_n), .intp(intp)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        we = 1'b1; addr = a; din = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [AW-1:0] a, input logic [DW-1:0] e);
        @(negedge clk);
        we = 1'b0; addr = a;
        @(negedge clk);
        chk(name, dout, e);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e;
        we = 1'b0; addr = '0; din = '0;
        tbl[0]  = '{1'b0, 12'h000, 16'h0000, 1'b1, 16'h0000};
        tbl[1]  = '{1'b1, 12'h000, 16'h1234, 1'b0, 16'h0000};
        tbl[2]  = '{1'b0, 12'h000, 16'h0000, 1'b1, 16'h1234};
        tbl[3]  = '{1'b1, 12'h010, 16'hFFF2, 1'b0, 16'h0000};
        tbl[4]  = '{1'b0, 12'h010, 16'h0000, 1'b1, 16'h0002};
        tbl[5]  = '{1'b1, 12'h019, 16'hABCD, 1'b0, 16'h0000};
        tbl[6]  = '{1'b0, 12'h019, 16'h0000, 1'b1, 16'hABCD};
        tbl[7]  = '{1'b1, 12'h01E, 16'h0055, 1'b0, 16'h0000};
        tbl[8]  = '{1'b0, 12'h01E, 16'h0000, 1'b1, 16'h0055};
        tbl[9]  = '{1'b0, 12'h01F, 16'h0000, 1'b1, 16'h0000};
        tbl[10] = '{1'b1, 12'h020, 16'hFFFF, 1'b0, 16'h0000};
        tbl[11] = '{1'b0, 12'h020, 16'h0000, 1'b1, 16'h0000};
        tbl[12] = '{1'b0, 12'h003, 16'h0000, 1'b1, 16'h0000};
        tbl[13] = '{1'b1, 12'h002, 16'hFFFF, 1'b0, 16'h0000};
        tbl[14] = '{1'b0, 12'h002, 16'h0000, 1'b1, 16'h0F0F};
        tbl[15] = '{1'b0, 12'h001, 16'h0000, 1'b1, 16'h0000};
        tbl[16] = '{1'b1, 12'h013, 16'h7777, 1'b0, 16'h0000};
        tbl[17] = '{1'b0, 12'h013, 16'h0000, 1'b1, 16'h0000};
        tbl[18] = '{1'b0, 12'h01C, 16'h0000, 1'b1, 16'h0000};

        // Reset state
        #12;
        chk("rst_dout", dout, 16'h0000);
        chk("rst_pwm_p", pwm_p, 4'hF);
        chk("rst_pwm_n", pwm_n, 4'h0);
        chk("rst_intp", intp, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Register map vectors, all channels disabled
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            we = tbl[i].we; addr = tbl[i].addr; din = tbl[i].din;
            @(negedge clk);
            we = 1'b0;
            if (tbl[i].chk) chk($sformatf("tbl%0d", i), dout, tbl[i].exp);
        end
        chk("dis_pol_pwm", pwm_p, 4'b1110);
        chk("tbl_intp", intp, 1'b0);
        reset_dut();

        // Up mode: TDIV=0, TOP=4, CMP=2, POL=1, IEN[0]=1
        wr(12'h011, 16'd4);
        wr(12'h012, 16'd2);
        wr(12'h002, 16'h0001);
        wr(12'h010, 16'h0003);
        addr = 12'h013;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            e = (k - 1) % 5;
            chk("up_cnt", dout, e);
            chk("up_pwm_p", pwm_p[0], (e < 2));
            chk("up_pwm_n", pwm_n[0], !(e < 2));
            chk("up_intp", intp, (k >= 6));
        end
        // Clear coinciding with an overflow: the set wins
        repeat (3) @(negedge clk);
        wr(12'h001, 16'h0001);
        addr = 12'h001;
        @(negedge clk);
        chk("iflg_set_wins", dout, 16'h0101);
        chk("intp_still", intp, 1'b1);
        // Clear on an idle cycle
        wr(12'h001, 16'h0001);
        chk("intp_lag", intp, 1'b1);
        addr = 12'h001;
        @(negedge clk);
        chk("intp_drop", intp, 1'b0);
        chk("iflg_cleared", dout, 16'h0100);
        // Disable mid-count
        wr(12'h010, 16'h0002);
        chk("dis_pwm_last", pwm_p[0], 1'b1);
        addr = 12'h013;
        @(negedge clk);
        chk("dis_pwm_p", pwm_p[0], 1'b0);
        chk("dis_pwm_n", pwm_n[0], 1'b1);
        chk("dis_cnt", dout, 16'h0000);
        reset_dut();

        // Up-down mode on ch1 with TDIV=2, TOP=3, CMP=1
        wr(12'h000, 16'd2);
        wr(12'h015, 16'd3);
        wr(12'h016, 16'd1);
        wr(12'h014, 16'h0005);
        addr = 12'h017;
        for (int j = 1; j <= 24; j++) begin
            @(negedge clk);
            e = (j < 2) ? 0 : tri_seq[((j - 2) / 3 + 1) % 6];
            chk("ud_cnt", dout, e);
            chk("ud_pwm_p", pwm_p[1], (e != 0));
            chk("ud_pwm_n", pwm_n[1], (e == 0));
        end
        rd_chk("ud_iflg", 12'h001, 16'h0202);
        reset_dut();

        // Shadowed TOP: 9 -> 4 written mid-period
        wr(12'h011, 16'd9);
        wr(12'h010, 16'h0001);
        wr(12'h011, 16'd4);
        addr = 12'h013;
        for (int j = 1; j <= 20; j++) begin
            @(negedge clk);
            e = (j + 1 <= 9) ? (j + 1) : ((j + 1 - 10) % 5);
            chk("shadow_cnt", dout, e);
        end
        rd_chk("top_readback", 12'h011, 16'd4);
        reset_dut();

        // One-shot, TOP=2, POL=1
        wr(12'h011, 16'd2);
        wr(12'h010, 16'h000B);
        repeat (6) @(negedge clk);
        rd_chk("os_ctr", 12'h010, 16'h000A);
        rd_chk("os_cnt", 12'h013, 16'h0000);
        chk("os_pwm", pwm_p[0], 1'b0);
        rd_chk("os_iflg", 12'h001, 16'h0101);
        wr(12'h001, 16'hFFFF);
        repeat (5) @(negedge clk);
        rd_chk("os_no_more", 12'h001, 16'h0000);
        reset_dut();

        // Asynchronous reset mid-count
        wr(12'h011, 16'd4);
        wr(12'h012, 16'd2);
        wr(12'h002, 16'h0001);
        wr(12'h010, 16'h0003);
        repeat (7) @(negedge clk);
        rd_chk("pre_rst_top", 12'h011, 16'd4);
        chk("pre_rst_intp", intp, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("arst_dout", dout, 16'h0000);
        chk("arst_pwm_p", pwm_p, 4'hF);
        chk("arst_pwm_n", pwm_n, 4'h0);
        chk("arst_intp", intp, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        rd_chk("post_rst_cnt", 12'h013, 16'h0000);
        wr(12'h000, 16'd7);
        rd_chk("post_rst_tdiv", 12'h000, 16'd7);
        rd_chk("unmapped_0ff", 12'h0FF, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
